// File: rtl/seq_signed_divider_if.sv
// Request/response bundle for seq_signed_divider; remainder exists only with SEQ_DIV_REM_EN.
// master drives requests and consumes responses, slave is the divider side.
interface seq_signed_divider_if #(
    parameter int W = 15
);
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] quotient;
`ifdef SEQ_DIV_REM_EN
    logic [W-1:0] remainder;
`endif
    logic         V;
    logic         DZ;

    modport master (
        output req_valid, dividend, divisor, rsp_ready,
        input  req_ready, rsp_valid, quotient,
`ifdef SEQ_DIV_REM_EN
        remainder,
`endif
        V, DZ
    );

    modport slave (
        input  req_valid, dividend, divisor, rsp_ready,
        output req_ready, rsp_valid, quotient,
`ifdef SEQ_DIV_REM_EN
        remainder,
`endif
        V, DZ
    );
endinterface

// File: rtl/seq_signed_divider.sv
// Restoring signed divider, one quotient bit per clock; SEQ_DIV_REM_EN adds the remainder output.
// Latency: W+2 edges from accept to response (1 edge for divide-by-zero).
// Backpressure: req_ready only in IDLE; result held in DONE until rsp_ready.
module seq_signed_divider #(
    parameter int W = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_signed_divider_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  shq_q, shq_d;      // dividend magnitude shifts out MSB-first, quotient bits shift in
    logic [W-1:0]  dmag_q, dmag_d;
    logic [W-1:0]  prem_q, prem_d;
    logic          sign_a_q, sign_a_d;
    logic          sign_b_q, sign_b_d;
    logic [W-1:0]  quot_q, quot_d;
    logic          v_q, v_d;
    logic          dz_q, dz_d;
`ifdef SEQ_DIV_REM_EN
    logic [W-1:0]  rem_q, rem_d;
`endif

    logic          accept;
    logic          neg_q;
    logic [W:0]    shifted;
    logic [W:0]    trial;

    assign accept  = bus.req_valid && (state_q == IDLE);
    assign neg_q   = sign_a_q ^ sign_b_q;
    assign shifted = {prem_q, shq_q[W-1]};
    assign trial   = shifted - {1'b0, dmag_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (bus.divisor == '0) ? DONE : CALC;
            CALC: if (count_q == '0) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.rsp_valid = (state_q == DONE);
        bus.quotient  = quot_q;
        bus.V         = v_q;
        bus.DZ        = dz_q;
`ifdef SEQ_DIV_REM_EN
        bus.remainder = rem_q;
`endif
    end

    always_comb begin
        count_d  = count_q;
        shq_d    = shq_q;
        dmag_d   = dmag_q;
        prem_d   = prem_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        quot_d   = quot_q;
        v_d      = v_q;
        dz_d     = dz_q;
`ifdef SEQ_DIV_REM_EN
        rem_d    = rem_q;
`endif
        case (state_q)
            IDLE: if (accept) begin
                sign_a_d = bus.dividend[W-1];
                sign_b_d = bus.divisor[W-1];
                shq_d    = bus.dividend[W-1] ? -bus.dividend : bus.dividend;
                dmag_d   = bus.divisor[W-1]  ? -bus.divisor  : bus.divisor;
                prem_d   = '0;
                count_d  = CW'(W - 1);
                if (bus.divisor == '0) begin
                    quot_d = '0;
                    v_d    = 1'b0;
                    dz_d   = 1'b1;
`ifdef SEQ_DIV_REM_EN
                    rem_d  = bus.dividend;
`endif
                end
            end
            CALC: begin
                shq_d   = {shq_q[W-2:0], ~trial[W]};
                prem_d  = trial[W] ? shifted[W-1:0] : trial[W-1:0];
                count_d = count_q - 1'b1;
            end
            FIX: begin
                quot_d = neg_q ? -shq_q : shq_q;
                // A magnitude of 2^(W-1) with equal signs can only come from MIN / -1
                v_d    = shq_q[W-1] && !neg_q;
                dz_d   = 1'b0;
`ifdef SEQ_DIV_REM_EN
                rem_d  = sign_a_q ? -prem_q : prem_q;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            shq_q    <= '0;
            dmag_q   <= '0;
            prem_q   <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            quot_q   <= '0;
            v_q      <= 1'b0;
            dz_q     <= 1'b0;
`ifdef SEQ_DIV_REM_EN
            rem_q    <= '0;
`endif
        end else begin
            count_q  <= count_d;
            shq_q    <= shq_d;
            dmag_q   <= dmag_d;
            prem_q   <= prem_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            quot_q   <= quot_d;
            v_q      <= v_d;
            dz_q     <= dz_d;
`ifdef SEQ_DIV_REM_EN
            rem_q    <= rem_d;
`endif
        end
    end
endmodule
